// File: rtl/ahb_slave_interface.sv
// AHB slave front end: address/data pipeline, region decode and burst beat counter.
// Define AHB_SLV_ERR_RESP_EN to compile in the two-cycle ERROR response FSM.
module ahb_slave_interface #(
    parameter logic [31:0] ERR_ADDR_LO = 32'h8000_0000,
    parameter logic [31:0] REGION_SIZE = 32'h0400_0000
) (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic        Hwrite,
    input  logic        Hreadyin,
    input  logic [1:0]  Htrans,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    output logic [31:0] Haddr1,
    output logic [31:0] Haddr2,
    output logic [31:0] Hwdata1,
    output logic [31:0] Hwdata2,
    output logic        Hwritereg,
    output logic        valid,
    output logic [2:0]  tempselx,
    output logic [3:0]  beat_cnt,
    output logic [1:0]  Hresp,
    output logic        err_stall
);

    localparam logic [1:0] TransNonseq = 2'b10;
    localparam logic [1:0] TransSeq    = 2'b11;

    // Decode arithmetic is widened so LO + 3*SIZE cannot wrap past 2^32.
    localparam logic [33:0] RegionLo  = {2'b00, ERR_ADDR_LO};
    localparam logic [33:0] RegionSz  = {2'b00, REGION_SIZE};
    localparam logic [33:0] RegionSz2 = RegionSz * 34'd2;
    localparam logic [33:0] RegionSpan = RegionSz * 34'd3;

    logic [33:0] addr_ext;
    logic [33:0] offset;
    logic        in_range;
    logic        active;
    logic        accept;

    assign addr_ext = {2'b00, Haddr};
    assign offset   = addr_ext - RegionLo;
    assign in_range = (addr_ext >= RegionLo) && (offset < RegionSpan);
    assign active   = Hreadyin && Htrans[1];

    always_comb begin
        tempselx = 3'b000;
        if (in_range) begin
            if (offset < RegionSz) begin
                tempselx = 3'b001;
            end else if (offset < RegionSz2) begin
                tempselx = 3'b010;
            end else begin
                tempselx = 3'b100;
            end
        end
    end

    assign valid = active && in_range && accept;

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            Haddr1    <= 32'h0;
            Haddr2    <= 32'h0;
            Hwdata1   <= 32'h0;
            Hwdata2   <= 32'h0;
            Hwritereg <= 1'b0;
        end else if (Hreadyin) begin
            Haddr1    <= Haddr;
            Haddr2    <= Haddr1;
            Hwdata1   <= Hwdata;
            Hwdata2   <= Hwdata1;
            Hwritereg <= Hwrite;
        end
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            beat_cnt <= 4'h0;
        end else if (active && accept) begin
            if (Htrans == TransNonseq) begin
                beat_cnt <= 4'h1;
            end else if (Htrans == TransSeq && beat_cnt != 4'hf) begin
                beat_cnt <= beat_cnt + 4'h1;
            end
        end
    end

`ifdef AHB_SLV_ERR_RESP_EN
    typedef enum logic [1:0] {StOkay, StErr1, StErr2} state_e;

    state_e state_q, state_d;

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q <= StOkay;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StOkay:  if (active && !in_range) state_d = StErr1;
            StErr1:  state_d = StErr2;
            StErr2:  state_d = StOkay;
            default: state_d = StOkay;
        endcase
    end

    always_comb begin
        Hresp     = 2'b00;
        err_stall = 1'b0;
        case (state_q)
            StErr1: begin
                Hresp     = 2'b01;
                err_stall = 1'b1;
            end
            StErr2:  Hresp = 2'b01;
            default: ;
        endcase
    end

    // Transfers arriving during the error response are dropped.
    assign accept = (state_q == StOkay);
`else
    assign Hresp     = 2'b00;
    assign err_stall = 1'b0;
    assign accept    = 1'b1;
`endif

endmodule

// File: tb/tb_ahb_slave_interface.sv
// Scoreboard bench for ahb_slave_interface; follows AHB_SLV_ERR_RESP_EN like the design.
module tb_ahb_slave_interface;

    localparam logic [31:0] LO = 32'h8000_0000;
    localparam logic [31:0] RS = 32'h0400_0000;

    logic        Hclk;
    logic        Hreset;
    logic        Hwrite;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic [31:0] Haddr1;
    logic [31:0] Haddr2;
    logic [31:0] Hwdata1;
    logic [31:0] Hwdata2;
    logic        Hwritereg;
    logic        valid;
    logic [2:0]  tempselx;
    logic [3:0]  beat_cnt;
    logic [1:0]  Hresp;
    logic        err_stall;

    ahb_slave_interface #(
        .ERR_ADDR_LO(LO),
        .REGION_SIZE(RS)
    ) dut (
        .Hclk      (Hclk),
        .Hreset    (Hreset),
        .Hwrite    (Hwrite),
        .Hreadyin  (Hreadyin),
        .Htrans    (Htrans),
        .Haddr     (Haddr),
        .Hwdata    (Hwdata),
        .Haddr1    (Haddr1),
        .Haddr2    (Haddr2),
        .Hwdata1   (Hwdata1),
        .Hwdata2   (Hwdata2),
        .Hwritereg (Hwritereg),
        .valid     (valid),
        .tempselx  (tempselx),
        .beat_cnt  (beat_cnt),
        .Hresp     (Hresp),
        .err_stall (err_stall)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    typedef struct packed {
        logic [31:0] a1;
        logic [31:0] a2;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        wr;
        logic [3:0]  cnt;
        logic [1:0]  resp;
        logic        stall;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference state; m_st: 0 OKAY, 1 ERR1, 2 ERR2.
    logic [31:0] m_a1, m_a2, m_d1, m_d2;
    logic        m_wr;
    logic [3:0]  m_cnt;
    int          m_st = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic hw, input logic hr, input logic [1:0] ht,
                        input logic [31:0] ha, input logic [31:0] hd);
        logic          act, inr, acc;
        logic [2:0]    sel;
        longint unsigned a64;
        int            idx;
        exp_t          e;
        exp_t          got;

        Hreset = rst; Hwrite = hw; Hreadyin = hr; Htrans = ht; Haddr = ha; Hwdata = hd;
        a64 = longint'(ha);
        act = hr && ht[1];
        inr = (a64 >= longint'(LO)) && (a64 < longint'(LO) + 3 * longint'(RS));
        sel = 3'b000;
        if (inr) begin
            idx = int'((a64 - longint'(LO)) / longint'(RS));
            sel = 3'b001 << idx;
        end
`ifdef AHB_SLV_ERR_RESP_EN
        acc = (m_st == 0);
`else
        acc = 1'b1;
`endif
        #1;
        if (!rst) begin
            check_eq("valid", 32'(valid), 32'(act && inr && acc));
            check_eq("tempselx", 32'(tempselx), 32'(sel));
        end

        if (rst) begin
            m_a1 = 0; m_a2 = 0; m_d1 = 0; m_d2 = 0; m_wr = 0; m_cnt = 0; m_st = 0;
        end else begin
            if (hr) begin
                m_a2 = m_a1; m_a1 = ha; m_d2 = m_d1; m_d1 = hd; m_wr = hw;
            end
            if (act && acc) begin
                if (ht == 2'b10) m_cnt = 4'd1;
                else if (m_cnt != 4'd15) m_cnt = m_cnt + 4'd1;
            end
`ifdef AHB_SLV_ERR_RESP_EN
            if (m_st == 1) m_st = 2;
            else if (m_st == 2) m_st = 0;
            else if (act && !inr) m_st = 1;
`endif
        end
        e.a1 = m_a1; e.a2 = m_a2; e.d1 = m_d1; e.d2 = m_d2; e.wr = m_wr; e.cnt = m_cnt;
        e.resp  = (m_st != 0) ? 2'b01 : 2'b00;
        e.stall = (m_st == 1);
        sb.push_back(e);

        @(posedge Hclk);
        #1;
        got = sb.pop_front();
        check_eq("Haddr1", Haddr1, got.a1);
        check_eq("Haddr2", Haddr2, got.a2);
        check_eq("Hwdata1", Hwdata1, got.d1);
        check_eq("Hwdata2", Hwdata2, got.d2);
        check_eq("Hwritereg", 32'(Hwritereg), 32'(got.wr));
        check_eq("beat_cnt", 32'(beat_cnt), 32'(got.cnt));
        check_eq("Hresp", 32'(Hresp), 32'(got.resp));
        check_eq("err_stall", 32'(err_stall), 32'(got.stall));
    endtask

    initial begin
        Hreset = 1'b1; Hwrite = 1'b0; Hreadyin = 1'b0; Htrans = 2'b00;
        Haddr = 32'h0; Hwdata = 32'h0;

        // Reset with random inputs.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'($urandom), 1'($urandom), 2'($urandom), $urandom, $urandom);
        end

        // Single write then data phase.
        step(1'b0, 1'b1, 1'b1, 2'b10, 32'h8000_0001, 32'h0);
        step(1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h80);
        step(1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);

        // INCR4 into region 1 with a three-cycle stall after beat 2.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b1, (i == 0) ? 2'b10 : 2'b11, 32'h8400_0000 + 32'(i), 32'(i + 16));
            if (i == 1) begin
                for (int j = 0; j < 3; j++) begin
                    step(1'b0, 1'b1, 1'b0, 2'b11, 32'h8400_0002, 32'hdead_0000 + 32'(j));
                end
            end
        end
        step(1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);

        // Decode boundaries and BUSY.
        step(1'b0, 1'b0, 1'b1, 2'b10, 32'h83ff_ffff, 32'h1);
        step(1'b0, 1'b0, 1'b1, 2'b10, 32'h8800_0000, 32'h2);
        step(1'b0, 1'b0, 1'b1, 2'b10, 32'h8bff_ffff, 32'h3);
        step(1'b0, 1'b0, 1'b1, 2'b01, 32'h8000_0010, 32'h4);
        step(1'b0, 1'b0, 1'b1, 2'b10, 32'h7fff_ffff, 32'h5);
        step(1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 2'b10, 32'h8c00_0000, 32'h6);
        step(1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);

        // Long burst to reach beat_cnt saturation.
        step(1'b0, 1'b1, 1'b1, 2'b10, 32'h8000_0000, 32'h0);
        for (int i = 1; i < 18; i++) begin
            step(1'b0, 1'b1, 1'b1, 2'b11, 32'h8000_0000 + 32'(4 * i), 32'(i));
        end

        // Erroneous NONSEQ followed by SEQs through ERR1, ERR2, then OKAY.
        step(1'b0, 1'b0, 1'b1, 2'b10, 32'h9000_0000, 32'h0);
        step(1'b0, 1'b0, 1'b1, 2'b11, 32'h8000_0004, 32'h11);
        step(1'b0, 1'b0, 1'b1, 2'b11, 32'h8000_0008, 32'h22);
        step(1'b0, 1'b0, 1'b1, 2'b11, 32'h8000_000c, 32'h33);

        // Reset while in ERR1.
        step(1'b0, 1'b0, 1'b1, 2'b10, 32'h9000_0000, 32'h0);
        step(1'b1, 1'b1, 1'b1, 2'b11, 32'h8000_0004, 32'h44);
        step(1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);

        // Random traffic around the decoded window.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 31) == 0), 1'($urandom), ($urandom_range(0, 3) != 0),
                 2'($urandom), $urandom_range(32'h7f00_0000, 32'h8d00_0000), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_slave_interface.md
AHB_SLAVE_INTERFACE -- requirements
Module: ahb_slave_interface

Interface
REQ-001 SHALL have parameter ERR_ADDR_LO, default 32'h8000_0000, meaning lowest decoded byte address.
REQ-002 SHALL have parameter REGION_SIZE, default 32'h0400_0000, meaning size of each of the three peripheral regions; regions are contiguous from ERR_ADDR_LO.
REQ-003 SHALL have port Hclk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Hreset, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have ports Hwrite, input, 1, and Hreadyin, input, 1: AHB transfer direction and the bus ready seen by the slave.
REQ-006 SHALL have ports Htrans, input, 2, Haddr, input, 32, and Hwdata, input, 32: AHB transfer type, address and write data.
REQ-007 SHALL have outputs Haddr1 and Haddr2, 32 each, the address delayed 1 and 2 accepted cycles.
REQ-008 SHALL have outputs Hwdata1 and Hwdata2, 32 each, the write data delayed 1 and 2 accepted cycles.
REQ-009 SHALL have output Hwritereg, 1, the registered Hwrite.
REQ-010 SHALL have outputs valid, 1, tempselx, 3, and beat_cnt, 4: transfer qualifier, one-hot region select and burst beat count.
REQ-011 SHALL have outputs Hresp, 2, and err_stall, 1: AHB response and the request to hold Hreadyout low.

Function
REQ-012 A transfer SHALL be active when Hreadyin=1 and Htrans is NONSEQ (2'b10) or SEQ (2'b11); IDLE (2'b00) and BUSY (2'b01) are never active.
REQ-013 In-range SHALL mean ERR_ADDR_LO <= Haddr < ERR_ADDR_LO+3*REGION_SIZE; region index = (Haddr-ERR_ADDR_LO)/REGION_SIZE.
REQ-014 tempselx SHALL be combinational one-hot: bit0, bit1 or bit2 for region 0, 1 or 2; 3'b000 when out of range.
REQ-015 valid SHALL be combinational: 1 only for an active, in-range transfer while the FSM is in OKAY.
REQ-016 When Hreadyin=1, Haddr1<=Haddr, Haddr2<=Haddr1, Hwdata1<=Hwdata, Hwdata2<=Hwdata1 and Hwritereg<=Hwrite; when Hreadyin=0, all SHALL hold.
REQ-017 beat_cnt SHALL load 1 on an active NONSEQ and increment on an active SEQ, saturating at 15, and hold otherwise.
REQ-018 The response FSM SHALL have three states: OKAY, ERR1 and ERR2.
REQ-019 In OKAY: Hresp=2'b00 and err_stall=0. An active out-of-range transfer SHALL move the FSM to ERR1.
REQ-020 In ERR1: Hresp=2'b01 and err_stall=1. The FSM SHALL always move to ERR2.
REQ-021 In ERR2: Hresp=2'b01 and err_stall=0. The FSM SHALL always move to OKAY.
REQ-022 Transfers presented in ERR1 or ERR2 SHALL be ignored: they do not trigger a new error and do not change beat_cnt.
REQ-023 An in-range SEQ that follows an erroneous NONSEQ, once the FSM is back in OKAY, SHALL assert valid normally.

Reset
REQ-024 With Hreset=1 at a rising edge, the following SHALL clear to 0 in the same cycle: Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg, beat_cnt, Hresp and err_stall; the FSM SHALL go to OKAY.
REQ-025 Reset asserted mid-burst or mid-error SHALL abort the burst or error with no residual state; reset takes priority over Hreadyin.

Configuration
REQ-026 Macro AHB_SLV_ERR_RESP_EN defined: the ERR1/ERR2 error response SHALL be compiled in per REQ-018 to REQ-022.
REQ-027 Macro AHB_SLV_ERR_RESP_EN undefined: the FSM SHALL be absent, Hresp SHALL be 2'b00 and err_stall 0 always; out-of-range transfers give valid=0 and tempselx=0 only.

Verification
REQ-028 Reset: hold Hreset=1 for 2 cycles with random inputs -> all registered outputs 0 and Hresp=00.
REQ-029 Single write: NONSEQ to 32'h8000_0001, Hwrite=1, then IDLE with Hwdata=8'h80 -> valid=1 and tempselx=001 in the address cycle; next edge Haddr1=32'h8000_0001, Hwritereg=1; following edge Hwdata1=32'h80.
REQ-030 INCR4 burst to 32'h8400_0000..03 -> tempselx=010 and valid=1 for 4 cycles; beat_cnt goes 1,2,3,4; Haddr2 lags Haddr by 2 cycles.
REQ-031 Stall: Hreadyin=0 for 3 cycles mid-burst -> valid=0, and pipeline registers and beat_cnt hold.
REQ-032 Error (macro defined): NONSEQ to 32'h9000_0000 -> valid=0 and tempselx=000; then Hresp=01 with err_stall=1, then Hresp=01 with err_stall=0, then OKAY; a SEQ offered during ERR1 is ignored.
REQ-033 Reset in ERR1 -> next cycle Hresp=00, err_stall=0; repeat REQ-032 with the macro undefined -> Hresp stays 00.
